// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM state encoding,
// default bus widths, word-address field positions and the round-robin
// pointer helper.
package sdram_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    // Default widths of the SDRAM_Interface command port
    localparam int ARB_ADDR_W = 22;
    localparam int ARB_DATA_W = 16;

    // Word address layout: bank[21:20], col[19:12], row[11:0]
    localparam int BANK_MSB = 21;
    localparam int BANK_LSB = 20;
    localparam int COL_MSB  = 19;
    localparam int COL_LSB  = 12;
    localparam int ROW_MSB  = 11;
    localparam int ROW_LSB  = 0;

    // Port index following idx, wrapping to 0 after the last port
    function automatic int rr_next(input int idx, input int num_ports);
        return (idx + 1 >= num_ports) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: scans the request vector starting at the
// priority pointer (wrapping) and returns the first requester as a one-hot
// grant plus its index. valid is low when nobody requests.
module rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     idx,
    output logic                 valid
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // First requesting port at or after the pointer wins
    always_comb begin
        grant    = '0;
        idx      = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            cand_idx = IDX_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid           = 1'b1;
                idx             = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the single SDRAM_Interface command port between NUM_PORTS
// requesters (port 0 = ADC capture writer, port 1 = host readback).
// Round-robin grant with one transaction in flight; sequences Req/Ack/Busy
// towards the SDRAM side and returns read data plus per-port Ack/Done.
// Optional build macro ARB_TIMEOUT_EN adds a watchdog that aborts a
// transaction stuck in REQ or WAIT for TIMEOUT_CY cycles and pulses PErr.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int TIMEOUT_CY = 1024
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [NUM_PORTS-1:0]        PReq,
    input  logic [NUM_PORTS-1:0]        PWnR,
    input  logic [NUM_PORTS*ADDR_W-1:0] PAddr,
    input  logic [NUM_PORTS*DATA_W-1:0] PWrData,
    output logic [NUM_PORTS-1:0]        PAck,
    output logic [NUM_PORTS-1:0]        PDone,
    output logic [DATA_W-1:0]           RdData,
    output logic [NUM_PORTS-1:0]        PErr,
    output logic                        MemReq,
    output logic                        MemWnR,
    output logic [ADDR_W-1:0]           MemAddr,
    output logic [DATA_W-1:0]           MemWrData,
    output logic                        MemWrOE,
    input  logic [DATA_W-1:0]           MemRdData,
    input  logic                        MemAck,
    input  logic                        MemBusy
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Reject out-of-range configurations at elaboration
    if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CY < 2) begin : g_param_check
        $error("sdram_port_arbiter: NUM_PORTS must be 2..8 and TIMEOUT_CY >= 2");
    end

    arb_state_t           state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     winner;
    logic [NUM_PORTS-1:0] winner_oh;
    logic [IDX_W-1:0]     ptr_after_winner;

    logic [NUM_PORTS-1:0] gnt_oh;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_valid;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr (
        .req   (PReq),
        .ptr   (ptr),
        .grant (gnt_oh),
        .idx   (gnt_idx),
        .valid (gnt_valid)
    );

    assign ptr_after_winner = IDX_W'(rr_next(int'(winner), NUM_PORTS));

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CY + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    // Counter starts at 0 on entry, so the TIMEOUT_CY-th cycle in a state aborts
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CY - 1));
`else
    assign PErr = '0;
`endif

    // Arbiter FSM: grant in IDLE, hand-shake Ack in REQ, wait for Busy to clear in WAIT
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            ptr       <= '0;
            winner    <= '0;
            winner_oh <= '0;
            MemReq    <= 1'b0;
            MemWnR    <= 1'b0;
            MemWrOE   <= 1'b0;
            MemAddr   <= '0;
            MemWrData <= '0;
            RdData    <= '0;
            PAck      <= '0;
            PDone     <= '0;
`ifdef ARB_TIMEOUT_EN
            PErr      <= '0;
            tmo_cnt   <= '0;
`endif
        end else begin
            PAck  <= '0;
            PDone <= '0;
`ifdef ARB_TIMEOUT_EN
            PErr  <= '0;
`endif
            case (state)
                IDLE: begin
                    if (gnt_valid && !MemBusy) begin
                        winner    <= gnt_idx;
                        winner_oh <= gnt_oh;
                        MemAddr   <= PAddr[int'(gnt_idx)*ADDR_W +: ADDR_W];
                        MemWrData <= PWrData[int'(gnt_idx)*DATA_W +: DATA_W];
                        MemWnR    <= PWnR[gnt_idx];
                        MemWrOE   <= PWnR[gnt_idx];
                        MemReq    <= 1'b1;
                        state     <= REQ;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end
                end

                REQ: begin
                    if (MemAck) begin
                        MemReq <= 1'b0;
                        PAck   <= winner_oh;
                        ptr    <= ptr_after_winner;
                        state  <= WAIT;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        MemReq  <= 1'b0;
                        MemWrOE <= 1'b0;
                        PErr    <= winner_oh;
                        ptr     <= ptr_after_winner;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
                    end
                end

                WAIT: begin
                    if (!MemBusy) begin
                        if (!MemWnR) begin
                            RdData <= MemRdData;
                        end
                        PDone   <= winner_oh;
                        MemWrOE <= 1'b0;
                        state   <= IDLE;
`ifdef ARB_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        MemWrOE <= 1'b0;
                        PErr    <= winner_oh;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: a small SDRAM_Interface
// model answers Req with Ack/Busy, a scoreboard queue holds the expected
// transactions in grant order and is checked as the arbiter issues them.
module tb_sdram_port_arbiter;

    localparam int NP = 2;
    localparam int AW = 22;
    localparam int DW = 16;
`ifdef ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic              Clk = 1'b0;
    logic              Rst;
    logic [NP-1:0]     PReq, PWnR, PAck, PDone, PErr;
    logic [NP*AW-1:0]  PAddr;
    logic [NP*DW-1:0]  PWrData;
    logic [DW-1:0]     RdData, MemWrData, MemRdData;
    logic              MemReq, MemWnR, MemWrOE, MemAck, MemBusy;
    logic [AW-1:0]     MemAddr;

    typedef struct {
        int            port;
        bit            wnr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] rd;
        bit            err;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    bit   cur_valid = 0;
    bit   req_seen  = 0;
    logic [NP-1:0] mon_oh;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    bit ack_en     = 1;
    bit force_busy = 0;
    int ack_delay  = 0;
    int busy_len   = 1;
    int m_phase    = 0;
    int mcnt       = 0;

    sdram_port_arbiter #(
        .NUM_PORTS  (NP),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT_CY (TMO)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .PReq      (PReq),
        .PWnR      (PWnR),
        .PAddr     (PAddr),
        .PWrData   (PWrData),
        .PAck      (PAck),
        .PDone     (PDone),
        .RdData    (RdData),
        .PErr      (PErr),
        .MemReq    (MemReq),
        .MemWnR    (MemWnR),
        .MemAddr   (MemAddr),
        .MemWrData (MemWrData),
        .MemWrOE   (MemWrOE),
        .MemRdData (MemRdData),
        .MemAck    (MemAck),
        .MemBusy   (MemBusy)
    );

    always #5 Clk = ~Clk;

    // Contents the SDRAM model returns for a read
    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (a == 22'h000010) return 16'h5A5A;
        return a[15:0] ^ 16'hC3C3;
    endfunction

    // SDRAM_Interface model, driven on the falling edge
    initial begin
        MemAck    = 1'b0;
        MemBusy   = 1'b0;
        MemRdData = '0;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                MemAck = 1'b0; MemBusy = 1'b0; m_phase = 0; mcnt = 0;
            end else if (force_busy) begin
                MemAck = 1'b0; MemBusy = 1'b1;
            end else if (m_phase == 0) begin
                MemAck  = 1'b0;
                MemBusy = 1'b0;
                if (MemReq && ack_en) begin
                    if (mcnt >= ack_delay) begin
                        MemAck    = 1'b1;
                        MemBusy   = 1'b1;
                        MemRdData = model_rd(MemAddr);
                        m_phase   = 1;
                        mcnt      = 0;
                    end else begin
                        mcnt++;
                    end
                end
            end else begin
                MemAck = 1'b0;
                if (mcnt >= busy_len) begin
                    MemBusy = 1'b0; m_phase = 0; mcnt = 0;
                end else begin
                    mcnt++;
                end
            end
        end
    end

    // Scoreboard: pop expected transaction when the arbiter issues it, check ack/done/err
    initial begin
        forever begin
            @(negedge Clk);
            if (Rst) begin
                cur_valid = 0;
                req_seen  = 0;
            end else begin
                if (MemReq && !req_seen) begin
                    req_seen = 1;
                    chk_cnt++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL sb_unexpected_req: addr=%h wnr=%b, no transaction expected", MemAddr, MemWnR);
                    end else begin
                        cur = exp_q.pop_front();
                        cur_valid = 1;
                        if ({MemWnR, MemWrOE, MemAddr} !== {cur.wnr, cur.wnr, cur.addr})
                            $display("FAIL sb_req_cmd: wnr/oe/addr=%b/%b/%h expected %b/%b/%h",
                                     MemWnR, MemWrOE, MemAddr, cur.wnr, cur.wnr, cur.addr);
                        else pass_cnt++;
                        if (cur.wnr) begin
                            chk_cnt++;
                            if (MemWrData !== cur.data)
                                $display("FAIL sb_wrdata: got %h expected %h", MemWrData, cur.data);
                            else pass_cnt++;
                        end
                    end
                end
                if (!MemReq) req_seen = 0;
                mon_oh = cur_valid ? (NP'(1) << cur.port) : '0;
                if (PAck != '0) begin
                    chk_cnt++;
                    if (!cur_valid || cur.err || PAck !== mon_oh)
                        $display("FAIL sb_pack: got %b expected %b", PAck, cur.err ? '0 : mon_oh);
                    else pass_cnt++;
                end
                if (PDone != '0 || PErr != '0) begin
                    chk_cnt++;
                    if (!cur_valid || PDone !== (cur.err ? '0 : mon_oh) || PErr !== (cur.err ? mon_oh : '0))
                        $display("FAIL sb_end: done/err=%b/%b expected port %0d err=%b", PDone, PErr, cur.port, cur.err);
                    else pass_cnt++;
                    if (cur_valid && !cur.err && !cur.wnr) begin
                        chk_cnt++;
                        if (RdData !== cur.rd)
                            $display("FAIL sb_rddata: got %h expected %h", RdData, cur.rd);
                        else pass_cnt++;
                    end
                    cur_valid = 0;
                end
            end
        end
    end

    task automatic push_exp(input int p, input bit w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] r, input bit e);
        txn_t t;
        t.port = p; t.wnr = w; t.addr = a; t.data = d; t.rd = r; t.err = e;
        exp_q.push_back(t);
    endtask

    task automatic set_port(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        PWnR[p]              = w;
        PAddr[p*AW +: AW]    = a;
        PWrData[p*DW +: DW]  = d;
    endtask

    // Play requesters until n_end transactions finish; hold keeps PReq up until then
    task automatic service(input int n_end, input int budget, input bit hold,
                           output int acks0, output int acks1, output bit ok);
        int ends;
        ends = 0; acks0 = 0; acks1 = 0; ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge Clk);
            if (PAck[0]) acks0++;
            if (PAck[1]) acks1++;
            if (!hold) PReq = PReq & ~PAck;
            PReq = PReq & ~PErr;
            if ((PDone | PErr) != '0) ends++;
            if (ends >= n_end) begin
                PReq = '0;
                ok   = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; PReq = '0; PWnR = '0; PAddr = '0; PWrData = '0;
        repeat (3) @(negedge Clk);
        chk_cnt++;
        if ({MemReq, MemWnR, MemWrOE, PAck, PDone, PErr, MemAddr, MemWrData, RdData} !== '0)
            $display("FAIL reset_outputs: req=%b wnr=%b oe=%b ack=%b done=%b err=%b addr=%h wd=%h rd=%h, expected all 0",
                     MemReq, MemWnR, MemWrOE, PAck, PDone, PErr, MemAddr, MemWrData, RdData);
        else pass_cnt++;
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        chk_cnt++;
        if (MemReq !== 1'b0) $display("FAIL idle_no_req: MemReq=%b expected 0", MemReq);
        else pass_cnt++;
    endtask

    task automatic test_single_write();
        int a0, a1; bit ok;
        set_port(0, 1'b1, 22'h123456, 16'hBEEF);
        push_exp(0, 1'b1, 22'h123456, 16'hBEEF, 16'h0, 1'b0);
        PReq[0] = 1'b1;
        @(negedge Clk);
        chk_cnt++;
        if (MemReq !== 1'b1) $display("FAIL write_req_latency: MemReq=%b expected 1", MemReq);
        else pass_cnt++;
        service(1, 40, 1'b0, a0, a1, ok);
        chk_cnt++;
        if (!ok || a0 != 1 || a1 != 0)
            $display("FAIL write_complete: ok=%b acks=%0d/%0d expected 1/1/0", ok, a0, a1);
        else pass_cnt++;
    endtask

    task automatic test_read();
        int a0, a1; bit ok;
        ack_delay = 3;
        set_port(1, 1'b0, 22'h000010, 16'h0);
        push_exp(1, 1'b0, 22'h000010, 16'h0, 16'h5A5A, 1'b0);
        PReq[1] = 1'b1;
        service(1, 40, 1'b0, a0, a1, ok);
        chk_cnt++;
        if (!ok || a0 != 0 || a1 != 1 || MemWrOE !== 1'b0)
            $display("FAIL read_complete: ok=%b acks=%0d/%0d oe=%b expected 1/0/1/0", ok, a0, a1, MemWrOE);
        else pass_cnt++;
        ack_delay = 0;
    endtask

    task automatic test_back_to_back();
        int a0, a1; bit ok;
        busy_len = 1;
        set_port(0, 1'b1, 22'h000100, 16'h0A0A);
        set_port(1, 1'b0, 22'h0ABCDE, 16'h0);
        for (int i = 0; i < 4; i++) begin
            push_exp(0, 1'b1, 22'h000100, 16'h0A0A, 16'h0, 1'b0);
            push_exp(1, 1'b0, 22'h0ABCDE, 16'h0, model_rd(22'h0ABCDE), 1'b0);
        end
        PReq = 2'b11;
        service(8, 200, 1'b1, a0, a1, ok);
        chk_cnt++;
        if (!ok || a0 != 4 || a1 != 4)
            $display("FAIL rr_fairness: ok=%b acks p0=%0d p1=%0d expected 4/4", ok, a0, a1);
        else pass_cnt++;
        repeat (3) @(negedge Clk);
        chk_cnt++;
        if (exp_q.size() != 0 || MemReq !== 1'b0)
            $display("FAIL rr_drained: pending=%0d MemReq=%b expected 0/0", exp_q.size(), MemReq);
        else pass_cnt++;
    endtask

    task automatic test_busy_hold();
        int a0, a1; bit ok; bit saw;
        saw = 0;
        force_busy = 1;
        repeat (2) @(negedge Clk);
        set_port(0, 1'b0, 22'h00002A, 16'h0);
        push_exp(0, 1'b0, 22'h00002A, 16'h0, model_rd(22'h00002A), 1'b0);
        PReq[0] = 1'b1;
        repeat (5) begin
            @(negedge Clk);
            if (MemReq) saw = 1;
        end
        chk_cnt++;
        if (saw) $display("FAIL busy_block: MemReq seen=1 expected 0 while Busy high");
        else pass_cnt++;
        force_busy = 0;
        service(1, 40, 1'b0, a0, a1, ok);
        chk_cnt++;
        if (!ok || a0 != 1) $display("FAIL busy_release: ok=%b acks=%0d expected 1/1", ok, a0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int a0, a1; bit ok; bit got_ack; bit stray;
        got_ack = 0; stray = 0;
        busy_len = 8;
        set_port(0, 1'b1, 22'h2AAAAA, 16'h7777);
        push_exp(0, 1'b1, 22'h2AAAAA, 16'h7777, 16'h0, 1'b0);
        PReq[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (PAck[0]) begin got_ack = 1; PReq[0] = 1'b0; break; end
        end
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        chk_cnt++;
        if (!got_ack || {MemReq, MemWnR, MemWrOE, PAck, PDone, PErr, MemAddr, MemWrData, RdData} !== '0)
            $display("FAIL rst_mid: ack=%b req=%b oe=%b done=%b addr=%h wd=%h rd=%h expected ack 1, rest 0",
                     got_ack, MemReq, MemWrOE, PDone, MemAddr, MemWrData, RdData);
        else pass_cnt++;
        @(negedge Clk);
        Rst = 1'b0;
        busy_len = 1;
        repeat (3) begin
            @(negedge Clk);
            if (PDone != '0 || MemReq) stray = 1;
        end
        chk_cnt++;
        if (stray) $display("FAIL rst_no_done: stray PDone/MemReq=1 expected 0 after reset");
        else pass_cnt++;
        set_port(0, 1'b1, 22'h111111, 16'h2222);
        set_port(1, 1'b0, 22'h000333, 16'h0);
        push_exp(0, 1'b1, 22'h111111, 16'h2222, 16'h0, 1'b0);
        push_exp(1, 1'b0, 22'h000333, 16'h0, model_rd(22'h000333), 1'b0);
        PReq = 2'b11;
        service(2, 60, 1'b0, a0, a1, ok);
        chk_cnt++;
        if (!ok || a0 != 1 || a1 != 1)
            $display("FAIL rst_ptr: ok=%b acks=%0d/%0d expected 1/1/1", ok, a0, a1);
        else pass_cnt++;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int a0, a1; bit ok; bit seen; int hi;
        seen = 0; hi = 0;
        ack_en = 0;
        set_port(0, 1'b1, 22'h3FFFFF, 16'h1234);
        set_port(1, 1'b0, 22'h000020, 16'h0);
        push_exp(0, 1'b1, 22'h3FFFFF, 16'h1234, 16'h0, 1'b1);
        push_exp(1, 1'b0, 22'h000020, 16'h0, model_rd(22'h000020), 1'b0);
        PReq = 2'b11;
        for (int c = 0; c < 100; c++) begin
            @(negedge Clk);
            if (MemReq) hi++;
            if (PErr != '0) begin seen = 1; PReq[0] = 1'b0; ack_en = 1; break; end
        end
        chk_cnt++;
        if (!seen || hi != TMO)
            $display("FAIL timeout_perr: seen=%b req_cycles=%0d expected 1/%0d", seen, hi, TMO);
        else pass_cnt++;
        ack_en = 1;
        service(1, 40, 1'b0, a0, a1, ok);
        chk_cnt++;
        if (!ok || a1 != 1) $display("FAIL timeout_next: ok=%b p1 acks=%0d expected 1/1", ok, a1);
        else pass_cnt++;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_back_to_back();
        test_busy_hold();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge Clk);
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL sb_leftover: pending=%0d expected 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
